// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory controller port among NUM_REQ requesters, req 0 first with starvation override
module mem_port_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int TYPE_W       = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       rdy_in,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req_en,
   input  logic [NUM_REQ*32-1:0]      req_addr,
   input  logic [NUM_REQ*TYPE_W-1:0]  req_type,
   input  logic [NUM_REQ*32-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]         req_rdy,
   output logic [31:0]                req_rdata,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       mc_en,
   output logic [31:0]                mc_addr,
   output logic [TYPE_W-1:0]          mc_type,
   output logic [31:0]                mc_wdata,
   input  logic                       mc_rdy,
   input  logic [31:0]                mc_rdata
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [1:0]    state;
   logic [GW-1:0] rr_ptr;
   logic [CW-1:0] cnt [1:NUM_REQ-1];
   logic          st_hit, rr_hit;
   logic [GW-1:0] st_win, rr_win, win;

   assign busy = state != IDLE;

   // winner: lowest starving requester, else req 0, else round robin from rr_ptr over 1..NUM_REQ-1
   always_comb begin
      st_hit = 1'b0;
      st_win = '0;
      rr_hit = 1'b0;
      rr_win = '0;
      for (int i = NUM_REQ - 1; i >= 1; i--)
         if (req_en[i] && cnt[i] == CW'(STARVE_LIMIT)) begin
            st_hit = 1'b1;
            st_win = GW'(i);
         end
      for (int k = NUM_REQ - 2; k >= 0; k--)
         if (req_en[(int'(rr_ptr) - 1 + k) % (NUM_REQ - 1) + 1]) begin
            rr_hit = 1'b1;
            rr_win = GW'((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1) + 1);
         end
      win = st_hit ? st_win : req_en[0] ? '0 : rr_win;
   end

   // grant FSM: latch the winner's request, hold it until mc_rdy, then pulse req_rdy for one cycle
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         state     <= IDLE;
         grant_id  <= '0;
         rr_ptr    <= GW'(1);
         mc_en     <= 1'b0;
         mc_addr   <= '0;
         mc_type   <= '0;
         mc_wdata  <= '0;
         req_rdy   <= '0;
         req_rdata <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            state   <= IDLE;
            mc_en   <= 1'b0;
            req_rdy <= '0;
         end else if (state == IDLE) begin
            if (|req_en) begin
               state    <= ISSUE;
               grant_id <= win;
               mc_en    <= 1'b1;
               mc_addr  <= req_addr[32*int'(win) +: 32];
               mc_type  <= req_type[TYPE_W*int'(win) +: TYPE_W];
               mc_wdata <= req_wdata[32*int'(win) +: 32];
               if (win != '0)
                  rr_ptr <= (win == GW'(NUM_REQ - 1)) ? GW'(1) : win + GW'(1);
            end
         end else if (state == ISSUE) begin
            if (mc_rdy) begin
               state     <= RELEASE;
               mc_en     <= 1'b0;
               req_rdy   <= NUM_REQ'(1) << grant_id;
               req_rdata <= mc_rdata;
            end
         end else begin
            state   <= IDLE;
            req_rdy <= '0;
         end
      end

   // starvation counters: count lost arbitrations while requesting, clear on grant, idle request or flush
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         for (int i = 1; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else if (rdy_in) begin
         for (int i = 1; i < NUM_REQ; i++)
            if (flush || (state == IDLE && (!req_en[i] || win == GW'(i))))
               cnt[i] <= '0;
            else if (state == IDLE && cnt[i] != CW'(STARVE_LIMIT))
               cnt[i] <= cnt[i] + 1'b1;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for mem_port_arbiter with hand-computed expectations
module tb_mem_port_arbiter;
   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, flush, mc_rdy;
   logic [2:0]  req_en, req_rdy;
   logic [95:0] req_addr, req_wdata;
   logic [11:0] req_type;
   logic [31:0] req_rdata, mc_addr, mc_wdata, mc_rdata;
   logic [1:0]  grant_id;
   logic        busy, mc_en;
   logic [3:0]  mc_type;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_port_arbiter #(.NUM_REQ(3), .TYPE_W(4), .STARVE_LIMIT(4)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
      .req_en(req_en), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
      .req_rdy(req_rdy), .req_rdata(req_rdata), .grant_id(grant_id), .busy(busy),
      .mc_en(mc_en), .mc_addr(mc_addr), .mc_type(mc_type), .mc_wdata(mc_wdata),
      .mc_rdy(mc_rdy), .mc_rdata(mc_rdata)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (mc_en) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_in);
      end
   endtask

   task automatic serve(input logic [31:0] rd, output logic [1:0] g, output bit ok);
      g = '0;
      wait_grant(ok);
      if (ok) begin
         g = grant_id;
         mc_rdy = 1'b1;
         mc_rdata = rd;
         @(negedge clk_in);
         mc_rdy = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; mc_rdy = 1'b0; mc_rdata = '0; req_en = '0;
      repeat (2) @(negedge clk_in);
      n_chk++;
      if ({mc_en, busy, req_rdy, grant_id} !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {mc_en, busy, req_rdy, grant_id});
      end
      n_chk++;
      if ({mc_addr, mc_type, mc_wdata, req_rdata} !== 100'b0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", {mc_addr, mc_type, mc_wdata, req_rdata});
      end
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);
      n_chk++;
      if ({mc_en, busy} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle: got %b expected 00", {mc_en, busy});
      end
   endtask

   task automatic test_single_read;
      req_en = 3'b001;
      @(negedge clk_in);
      n_chk++;
      if ({mc_en, busy, grant_id} !== 4'b1100) begin
         n_fail++; $display("FAIL read_issue: got %b expected 1100", {mc_en, busy, grant_id});
      end
      n_chk++;
      if ({mc_addr, mc_type, mc_wdata} !== {32'h1000, 4'h1, 32'hA0}) begin
         n_fail++; $display("FAIL read_fields: got %h expected %h", {mc_addr, mc_type, mc_wdata}, {32'h1000, 4'h1, 32'hA0});
      end
      repeat (3) @(negedge clk_in);
      n_chk++;
      if ({mc_en, req_rdy, mc_addr} !== {1'b1, 3'b000, 32'h1000}) begin
         n_fail++; $display("FAIL read_hold: got %h expected %h", {mc_en, req_rdy, mc_addr}, {1'b1, 3'b000, 32'h1000});
      end
      mc_rdy = 1'b1; mc_rdata = 32'hDEADBEEF;
      @(negedge clk_in);
      mc_rdy = 1'b0; mc_rdata = '0; req_en = 3'b000;
      n_chk++;
      if ({req_rdy, req_rdata, mc_en, busy} !== {3'b001, 32'hDEADBEEF, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL read_done: got %h expected %h", {req_rdy, req_rdata, mc_en, busy}, {3'b001, 32'hDEADBEEF, 1'b0, 1'b1});
      end
      @(negedge clk_in);
      n_chk++;
      if ({req_rdy, busy} !== 4'b0000) begin
         n_fail++; $display("FAIL read_release: got %b expected 0000", {req_rdy, busy});
      end
      @(negedge clk_in);
      n_chk++;
      if (mc_en !== 1'b0) begin
         n_fail++; $display("FAIL read_no_regrant: got %b expected 0", mc_en);
      end
   endtask

   task automatic test_priority;
      int exp_g[5] = '{0, 0, 0, 0, 2};
      logic [1:0] g;
      bit ok;
      req_en = 3'b101;
      for (int k = 0; k < 5; k++) begin
         serve(32'h100 + k, g, ok);
         n_chk++;
         if (!ok || g !== 2'(exp_g[k]) || req_rdy !== 3'(3'b001 << exp_g[k])) begin
            n_fail++; $display("FAIL priority_%0d: got ok=%0d grant=%0d rdy=%b expected grant=%0d", k, ok, g, req_rdy, exp_g[k]);
         end
      end
      req_en = 3'b000;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_round_robin;
      int exp_g[4] = '{1, 2, 1, 2};
      logic [1:0] g;
      bit ok;
      req_en = 3'b110;
      for (int k = 0; k < 4; k++) begin
         serve(32'h200 + k, g, ok);
         n_chk++;
         if (!ok || g !== 2'(exp_g[k]) || req_rdy !== 3'(3'b001 << exp_g[k]) || req_rdata !== 32'h200 + k) begin
            n_fail++; $display("FAIL rr_%0d: got ok=%0d grant=%0d rdy=%b data=%h expected grant=%0d", k, ok, g, req_rdy, req_rdata, exp_g[k]);
         end
      end
      req_en = 3'b000;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_flush;
      int exp_g[5] = '{0, 0, 0, 0, 2};
      logic [1:0] g;
      bit ok;
      req_en = 3'b101;
      for (int k = 0; k < 2; k++) begin
         serve(32'h300, g, ok);
         n_chk++;
         if (!ok || g !== 2'd0) begin
            n_fail++; $display("FAIL flush_pre_%0d: got ok=%0d grant=%0d expected 0", k, ok, g);
         end
      end
      wait_grant(ok);
      n_chk++;
      if (!ok || grant_id !== 2'd0) begin
         n_fail++; $display("FAIL flush_third: got ok=%0d grant=%0d expected 0", ok, grant_id);
      end
      flush = 1'b1;
      @(negedge clk_in);
      flush = 1'b0;
      n_chk++;
      if ({mc_en, busy, req_rdy} !== 5'b0) begin
         n_fail++; $display("FAIL flush_issue: got %b expected 00000", {mc_en, busy, req_rdy});
      end
      for (int k = 0; k < 5; k++) begin
         serve(32'h310 + k, g, ok);
         n_chk++;
         if (!ok || g !== 2'(exp_g[k])) begin
            n_fail++; $display("FAIL flush_cnt_%0d: got ok=%0d grant=%0d expected %0d", k, ok, g, exp_g[k]);
         end
      end
      req_en = 3'b000;
      repeat (3) @(negedge clk_in);
      req_en = 3'b010;
      wait_grant(ok);
      n_chk++;
      if (!ok || grant_id !== 2'd1) begin
         n_fail++; $display("FAIL flush_mc_grant: got ok=%0d grant=%0d expected 1", ok, grant_id);
      end
      mc_rdy = 1'b1; mc_rdata = 32'h12345678; flush = 1'b1; req_en = 3'b000;
      @(negedge clk_in);
      mc_rdy = 1'b0; flush = 1'b0;
      n_chk++;
      if ({mc_en, busy, req_rdy} !== 5'b0) begin
         n_fail++; $display("FAIL flush_mc_rdy: got %b expected 00000", {mc_en, busy, req_rdy});
      end
      @(negedge clk_in);
      n_chk++;
      if ({mc_en, busy, req_rdy} !== 5'b0) begin
         n_fail++; $display("FAIL flush_mc_after: got %b expected 00000", {mc_en, busy, req_rdy});
      end
   endtask

   task automatic test_freeze;
      bit ok;
      req_en = 3'b100;
      wait_grant(ok);
      n_chk++;
      if (!ok || grant_id !== 2'd2 || mc_addr !== 32'h3000) begin
         n_fail++; $display("FAIL freeze_grant: got ok=%0d grant=%0d addr=%h expected 2 3000", ok, grant_id, mc_addr);
      end
      rdy_in = 1'b0; flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         n_chk++;
         if ({mc_en, busy, grant_id, mc_addr, mc_type, req_rdy} !== {1'b1, 1'b1, 2'd2, 32'h3000, 4'h2, 3'b000}) begin
            n_fail++; $display("FAIL freeze_hold_%0d: got en=%b busy=%b grant=%0d addr=%h type=%h rdy=%b", k, mc_en, busy, grant_id, mc_addr, mc_type, req_rdy);
         end
      end
      rdy_in = 1'b1; flush = 1'b0;
      @(negedge clk_in);
      n_chk++;
      if ({mc_en, grant_id, mc_wdata} !== {1'b1, 2'd2, 32'hC2}) begin
         n_fail++; $display("FAIL freeze_resume: got %h expected %h", {mc_en, grant_id, mc_wdata}, {1'b1, 2'd2, 32'hC2});
      end
      mc_rdy = 1'b1; mc_rdata = 32'hCAFEF00D;
      @(negedge clk_in);
      mc_rdy = 1'b0; req_en = 3'b000;
      n_chk++;
      if ({req_rdy, req_rdata} !== {3'b100, 32'hCAFEF00D}) begin
         n_fail++; $display("FAIL freeze_done: got %h expected %h", {req_rdy, req_rdata}, {3'b100, 32'hCAFEF00D});
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic test_async_reset;
      logic [1:0] g;
      bit ok;
      req_en = 3'b010;
      wait_grant(ok);
      n_chk++;
      if (!ok || grant_id !== 2'd1) begin
         n_fail++; $display("FAIL areset_grant: got ok=%0d grant=%0d expected 1", ok, grant_id);
      end
      #2 rst_n_in = 1'b0;
      #1;
      n_chk++;
      if ({mc_en, busy, grant_id, mc_addr, req_rdy} !== 39'b0) begin
         n_fail++; $display("FAIL areset_now: got %h expected 0", {mc_en, busy, grant_id, mc_addr, req_rdy});
      end
      @(negedge clk_in);
      rst_n_in = 1'b1; req_en = 3'b110;
      serve(32'h55AA55AA, g, ok);
      req_en = 3'b000;
      n_chk++;
      if (!ok || g !== 2'd1 || req_rdy !== 3'b010 || req_rdata !== 32'h55AA55AA) begin
         n_fail++; $display("FAIL areset_after: got ok=%0d grant=%0d rdy=%b data=%h expected 1 010 55aa55aa", ok, g, req_rdy, req_rdata);
      end
      repeat (2) @(negedge clk_in);
   endtask

   initial begin
      req_addr  = {32'h3000, 32'h2000, 32'h1000};
      req_type  = {4'h2, 4'h9, 4'h1};
      req_wdata = {32'hC2, 32'hB1, 32'hA0};
      test_reset;
      test_single_read;
      test_priority;
      test_round_robin;
      test_flush;
      test_freeze;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
